// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver (LSB first, idle-high line, fixed baud).
//
// The raw line is double-flopped. A falling edge seen in IDLE starts a frame.
// The start bit is re-checked half a bit later, so short low glitches are
// rejected. Every following sample (8 data bits, then the stop bit) is taken
// one full bit period after the previous one, which keeps each sample at
// mid-bit. A good byte is presented with a valid/ack handshake. Framing and
// overrun errors are reported as single-cycle pulses.
//
// Parameters:
//   BAUD_RATE    serial bit rate
//   CLOCK_SPEED  clk frequency in Hz
//   TICKS_PER_BIT (derived) = CLOCK_SPEED / BAUD_RATE. Must be >= 4.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   serial_in    raw asynchronous serial line, idle high
//   rx_data      last correctly framed byte, held until the next good byte
//   rx_valid     high while rx_data is unread
//   rx_ack       consumer acknowledge, clears rx_valid
//   frame_error  one-cycle pulse when the stop bit is sampled low
//   overrun      one-cycle pulse when a good byte completes while still valid
//   busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLOCK_SPEED = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int TICKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CNT_W         = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  // The start bit is checked at half a bit. Each later sample is one full bit after the previous one.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // Synchroniser. rx_s_q is the only copy of the line that the logic uses.
  logic sync1_q;
  logic rx_s_q;

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [2:0]       idx_q,         idx_d;
  logic [7:0]       shift_q,       shift_d;
  logic [7:0]       rx_data_q,     rx_data_d;
  logic             rx_valid_q,    rx_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             overrun_q,     overrun_d;
  logic             good_byte;

  always_comb begin
    // NOTE: every signal assigned here gets a default first. Any path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    good_byte     = 1'b0;
    // An ack clears the valid flag. Writing a new byte below overrides this (set wins).
    rx_valid_d    = rx_valid_q & ~rx_ack;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch, not a start bit.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // The line sends LSB first, so shift right and put each new bit in at the top.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Return to IDLE at mid-stop-bit so that a start bit right after the stop bit is caught.
            good_byte = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        // Wait for the line to go high again so that a held-low line (break) gives only one frame_error.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (good_byte) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      // An ack that lands on the completion cycle counts as a read, so that case is not an overrun.
      overrun_d  = rx_valid_q & ~rx_ack;
    end
  end

  // NOTE: state registers use non-blocking assignments only. Then every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Both synchroniser flops reset to the idle level, so leaving reset never looks like a start bit.
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= serial_in;
      rx_s_q        <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (T = 16 clocks per bit).
//
// The stimulus side drives whole serial frames. For each frame it pushes the
// expected outcome onto a queue: a byte or a framing error, the cycle it must
// appear on, and whether it must come with an overrun. A separate monitor
// watches the DUT outputs, pops the queue for each event it sees and
// compares. Directed scenarios come first, then a randomized mix of frames,
// glitches and framing errors.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int T = 16;
  localparam int H = T / 2;

  typedef enum int {EV_BYTE, EV_FE} ev_kind_e;
  typedef enum int {ACK_NONE, ACK_AUTO, ACK_AT, ACK_MANUAL} ack_mode_e;

  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    bit         ovr;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int        n_checks = 0;
  int        n_errors = 0;
  int        cyc = 0;
  exp_t      exp_q[$];
  ack_mode_e ack_mode = ACK_NONE;
  int        ack_at = 0;
  bit        manual_ack = 1'b0;

  uart_rx #(
    .BAUD_RATE  (1),
    .CLOCK_SPEED(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer side. Changes take effect 2 time units after each rising edge.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        ACK_NONE:   rx_ack = 1'b0;
        ACK_AUTO:   rx_ack = ($urandom_range(0, 3) == 0);
        ACK_AT:     rx_ack = (cyc == ack_at - 1);
        ACK_MANUAL: rx_ack = manual_ack;
        default:    rx_ack = 1'b0;
      endcase
    end
  end

  // Monitor. It samples on the falling edge. A new byte shows up as valid
  // rising, as valid held through an ack, or as an overrun pulse.
  initial begin
    bit   prev_valid;
    bit   prev_ack;
    bit   new_byte;
    exp_t e;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        new_byte = rx_valid && (!prev_valid || prev_ack || overrun);
        if (frame_error) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame_error at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_fe", EV_FE, e.kind);
            check("fe_time", cyc, e.due);
          end
        end
        if (new_byte) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte 0x%0h at cycle %0d", rx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_byte", EV_BYTE, e.kind);
            check("rx_data", rx_data, e.data);
            check("byte_time", cyc, e.due);
            check("overrun", overrun, e.ovr);
          end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          e = exp_q.pop_front();
          n_checks++;
          n_errors++;
          $display("FAIL missing_event kind %0d data 0x%0h due %0d, now %0d", e.kind, e.data, e.due, cyc);
        end
        prev_valid = rx_valid;
        prev_ack   = rx_ack;
      end else begin
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: no finish after 60000 cycles (%0d checks, %0d errors)", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // The driver always resumes 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    tick(n);
  endtask

  // Sends one frame (start, 8 data bits LSB first, stop), then optionally
  // holds the line low. The start level is driven right after edge e. The
  // synchronised line first shows it at edge e+2, and the result must appear
  // H+9T+1 edges later.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int hold_low, input bit ovr, input bit ack_on_done);
    exp_t       e;
    logic [9:0] f;
    f      = {stop_bit, data, 1'b0};
    e.kind = stop_bit ? EV_BYTE : EV_FE;
    e.data = data;
    e.ovr  = ovr;
    e.due  = cyc + 3 + H + 9 * T;
    exp_q.push_back(e);
    if (ack_on_done) begin
      ack_at   = e.due;
      ack_mode = ACK_AT;
    end
    for (int i = 0; i < 10; i++) begin
      serial_in = f[i];
      tick(T);
    end
    if (hold_low > 0) begin
      serial_in = 1'b0;
      tick(hold_low);
    end
    serial_in = 1'b1;
  endtask

  task automatic wait_valid_low();
    for (int i = 0; i < 64 && rx_valid; i++) tick(1);
    check("valid_released", rx_valid, 1'b0);
  endtask

  initial begin
    logic [9:0] pf;
    int         r;
    rst       = 1'b0;
    serial_in = 1'b1;
    tick(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    idle(5);

    // 1: single frame, latency, manual ack.
    ack_mode = ACK_NONE;
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    idle(2);
    check("t1_valid_held", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    ack_mode   = ACK_MANUAL;
    manual_ack = 1'b1;
    tick(1);
    check("t1_ack_clears", rx_valid, 1'b0);
    manual_ack = 1'b0;
    ack_mode   = ACK_AUTO;
    idle(2);

    // 2: back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0);
    idle(T);
    wait_valid_low();

    // 3: 4-cycle low glitch on an idle line.
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    check("t3_busy_during_glitch", busy, 1'b1);
    tick(12);
    check("t3_busy_after", busy, 1'b0);
    check("t3_valid_after", rx_valid, 1'b0);
    check("t3_fe_after", frame_error, 1'b0);
    idle(T);

    // 4: bad stop bit plus a break, then a good frame.
    send_frame(8'h3C, 1'b0, 40, 1'b0, 1'b0);
    idle(T);
    check("t4_valid_after_fe", rx_valid, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    idle(T);

    // 5: overrun, then an ack on the completion cycle (set wins, no overrun).
    wait_valid_low();
    ack_mode = ACK_NONE;
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b1, 1'b0);
    idle(4);
    check("t5_valid_after_overrun", rx_valid, 1'b1);
    check("t5_data_newest", rx_data, 8'h22);
    send_frame(8'h33, 1'b1, 0, 1'b0, 1'b1);
    ack_mode = ACK_NONE;
    idle(4);
    check("t5_valid_set_wins", rx_valid, 1'b1);
    check("t5_data_set_wins", rx_data, 8'h33);

    // 6: reset in the middle of data bit 4, then a clean frame.
    pf = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 5 * T + H; c++) begin
      serial_in = pf[c / T];
      tick(1);
    end
    check("t6_busy_midframe", busy, 1'b1);
    rst       = 1'b0;
    serial_in = 1'b1;
    tick(2);
    check("t6_rst_rx_data", rx_data, 8'h00);
    check("t6_rst_rx_valid", rx_valid, 1'b0);
    check("t6_rst_frame_error", frame_error, 1'b0);
    check("t6_rst_overrun", overrun, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    rst      = 1'b1;
    ack_mode = ACK_AUTO;
    idle(4);
    send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
    idle(T);

    // Randomized mix: good frames with random gaps, glitches and framing errors.
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        serial_in = 1'b0;
        tick($urandom_range(1, H - 2));
        idle(2 * T);
      end else if (r == 1) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(0, 30), 1'b0, 1'b0);
        idle($urandom_range(4, T));
      end else begin
        send_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0);
        idle($urandom_range(0, T));
      end
    end

    idle(T);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
